// File: rtl/ldpc_hb_outbuf_if.sv
// ldpc_hb_outbuf_if -- byte stream from the LDPC hard-bit output buffer.
//   dout      8  output byte, bit0 is the earliest codeword bit
//   dout_vld  1  byte valid
//   dout_rdy  1  downstream ready
//   dout_sof  1  first byte of a block
//   dout_eof  1  last byte of a block
//   blk_fail  1  decoder-failure status of the block being streamed
// master: buffer side, slave: downstream consumer.
interface ldpc_hb_outbuf_if;
  logic [7:0] dout;
  logic       dout_vld;
  logic       dout_rdy;
  logic       dout_sof;
  logic       dout_eof;
  logic       blk_fail;

  modport master (output dout, dout_vld, dout_sof, dout_eof, blk_fail,
                  input  dout_rdy);
  modport slave  (input  dout, dout_vld, dout_sof, dout_eof, blk_fail,
                  output dout_rdy);
endinterface

// File: rtl/ldpc_hb_outbuf.sv
// ldpc_hb_outbuf -- ping-pong buffer behind the LDPC decoder hard-bit output.
// Keeps the first INFO_WORDS 16-bit words of every BLK_WORDS-word block and
// streams them out as bytes (low byte first) while the next block is written.
// Ports:
//   CLK, RESET_N        clock (rising edge), async active-low reset
//   hb_vlid, hardbit    decoder hard-bit words, one per cycle, never stalled
//   dec_fin, dec_fail   decoder finished pulse and its failure flag
//   obus                byte stream (ldpc_hb_outbuf_if.master)
//   ovf                 sticky: a block was dropped, both banks were full
//   busy                a bank is full or being read
//   fail_cnt            committed (and dropped) failed blocks, saturating;
//                       present only with `define LDPC_OBUF_FAILCNT_EN
// Read FSM:
//   state   | meaning
//   R_IDLE  | wait for bank[rbank] to become full
//   R_FETCH | load byte rcnt of bank[rbank] into the output register
//   R_SEND  | byte offered; advance on handshake, release bank after eof
module ldpc_hb_outbuf #(
  parameter int BLK_WORDS  = 640,
  parameter int INFO_WORDS = 512,
  parameter int AW         = 9
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             hb_vlid,
  input  logic [15:0]      hardbit,
  input  logic             dec_fin,
  input  logic             dec_fail,
  ldpc_hb_outbuf_if.master obus,
  output logic             ovf,
  output logic             busy
`ifdef LDPC_OBUF_FAILCNT_EN
  ,
  output logic [15:0]      fail_cnt
`endif
);

  localparam int WCW = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
  localparam int RCW = AW + 1;
  localparam logic [WCW-1:0] W_LAST = WCW'(BLK_WORDS - 1);
  localparam logic [RCW-1:0] R_LAST = RCW'(2 * INFO_WORDS - 1);
  localparam bit KEEP_ALL = (INFO_WORDS >= BLK_WORDS);

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_FETCH = 2'd1;
  localparam logic [1:0] R_SEND  = 2'd2;

  // Both banks in one array, bank select is the address MSB.
  logic [15:0]    mem [0:(2**RCW)-1];

  logic [WCW-1:0] wcnt;
  logic           wbank;
  logic           drop_q;
  logic           fail_pend;
  logic [1:0]     full;
  logic [1:0]     fbit;
  logic [1:0]     rstate;
  logic           rbank;
  logic [RCW-1:0] rcnt;

  logic           fin_fail;
  logic           last_w;
  logic           drop_now;
  logic           commit;
  logic           info_w;
  logic           blk_fail_w;
  logic           hs;
  logic           release_b;
  logic           adv;
  logic           load;
  logic [RCW-1:0] rsel;
  logic [15:0]    rword;

  assign fin_fail   = dec_fin & dec_fail;
  assign last_w     = hb_vlid & (wcnt == W_LAST);
  // The drop decision is taken on the first word and held for the block.
  assign drop_now   = (wcnt == '0) ? full[wbank] : drop_q;
  assign commit     = last_w & ~drop_now;
  assign info_w     = KEEP_ALL | (wcnt < WCW'(INFO_WORDS));
  assign blk_fail_w = fail_pend | fin_fail;

  assign hs         = (rstate == R_SEND) & obus.dout_vld & obus.dout_rdy;
  assign release_b  = hs & obus.dout_eof;
  assign adv        = hs & ~obus.dout_eof;
  assign load       = (rstate == R_FETCH) | adv;
  // Byte index being loaded this cycle; the word is read combinationally so
  // the next byte is ready in the handshake cycle (1 byte/cycle sustained).
  assign rsel       = adv ? rcnt + RCW'(1) : rcnt;
  assign rword      = mem[{rbank, rsel[RCW-1:1]}];

  assign busy       = (|full) | (rstate != R_IDLE);

  always_ff @(posedge CLK) begin
    if (hb_vlid && info_w && !drop_now)
      mem[{wbank, AW'(wcnt)}] <= hardbit;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wcnt      <= '0;
      wbank     <= 1'b0;
      drop_q    <= 1'b0;
      fail_pend <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (fin_fail)
        fail_pend <= 1'b1;
      if (hb_vlid) begin
        wcnt <= last_w ? '0 : wcnt + WCW'(1);
        if (wcnt == '0) begin
          drop_q <= full[wbank];
          if (full[wbank])
            ovf <= 1'b1;
        end
        if (last_w)
          fail_pend <= 1'b0;
        if (commit)
          wbank <= ~wbank;
      end
    end
  end

  // Commit and release always target different banks, so both may land in
  // the same cycle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      full <= 2'b00;
      fbit <= 2'b00;
    end else begin
      if (release_b)
        full[rbank] <= 1'b0;
      if (commit) begin
        full[wbank] <= 1'b1;
        fbit[wbank] <= blk_fail_w;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rstate        <= R_IDLE;
      rbank         <= 1'b0;
      rcnt          <= '0;
      obus.dout     <= 8'd0;
      obus.dout_vld <= 1'b0;
      obus.dout_sof <= 1'b0;
      obus.dout_eof <= 1'b0;
      obus.blk_fail <= 1'b0;
    end else begin
      case (rstate)
        R_IDLE:  if (full[rbank]) rstate <= R_FETCH;
        R_FETCH: rstate <= R_SEND;
        R_SEND: begin
          if (release_b) begin
            rbank         <= ~rbank;
            rcnt          <= '0;
            obus.dout_vld <= 1'b0;
            rstate        <= full[~rbank] ? R_FETCH : R_IDLE;
          end else if (adv) begin
            rcnt <= rsel;
          end
        end
        default: rstate <= R_IDLE;
      endcase
      if (load) begin
        obus.dout     <= rsel[0] ? rword[15:8] : rword[7:0];
        obus.dout_sof <= (rsel == '0);
        obus.dout_eof <= (rsel == R_LAST);
        obus.dout_vld <= 1'b1;
      end
      if (rstate == R_FETCH)
        obus.blk_fail <= fbit[rbank];
    end
  end

`ifdef LDPC_OBUF_FAILCNT_EN
  // Counted at the last word of every block, so dropped failed blocks count.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      fail_cnt <= 16'd0;
    else if (last_w && blk_fail_w && fail_cnt != 16'hFFFF)
      fail_cnt <= fail_cnt + 16'd1;
  end
`endif

endmodule
